// File: rtl/alu_issue_stage.sv
// alu_issue_stage: two-stage valid/ready issue wrapper around a 16-bit ALU with accumulator chaining and result flags
module alu_issue_stage #(
  parameter int WIDTH = 16,
  parameter int OPW = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OPW-1:0]   in_op,
  input  logic             in_acc_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_illegal,
  output logic [WIDTH-1:0] acc
);
  logic s1_valid, s2_take, s1_adv, hazard, accept;
  logic is_add, is_sub, illegal, carry, ovf;
  logic [WIDTH:0] sum, dif;
  logic [WIDTH-1:0] res;
  assign s2_take = !out_valid || out_ready;
  assign s1_adv = s1_valid && s2_take;
  assign hazard = in_acc_sel && s1_valid;
  assign in_ready = (!s1_valid || s2_take) && !hazard;
  assign accept = in_valid && in_ready;
  assign sum = {1'b0, alu_a} + {1'b0, alu_b};
  assign dif = {1'b0, alu_a} - {1'b0, alu_b};
  always_comb begin
    is_add = alu_ctrl == OPW'(0);
    is_sub = alu_ctrl == OPW'(1);
    illegal = alu_ctrl > OPW'(4);
    res = illegal ? '0 : alu_result;
    carry = is_add ? sum[WIDTH] : is_sub ? dif[WIDTH] : 1'b0;
    ovf = is_add ? (alu_a[WIDTH-1] == alu_b[WIDTH-1] && sum[WIDTH-1] != alu_a[WIDTH-1]) :
          is_sub ? (alu_a[WIDTH-1] != alu_b[WIDTH-1] && dif[WIDTH-1] != alu_a[WIDTH-1]) : 1'b0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      alu_a <= '0;
      alu_b <= '0;
      alu_ctrl <= '0;
      out_valid <= 1'b0;
      out_result <= '0;
      out_zero <= 1'b0;
      out_carry <= 1'b0;
      out_ovf <= 1'b0;
      out_illegal <= 1'b0;
      acc <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        alu_a <= in_acc_sel ? acc : in_a;
        alu_b <= in_b;
        alu_ctrl <= in_op;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
      if (s1_adv) begin
        out_valid <= 1'b1;
        out_result <= res;
        out_zero <= res == '0;
        out_carry <= carry;
        out_ovf <= ovf;
        out_illegal <= illegal;
        if (!illegal) acc <= alu_result;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed self-checking bench for alu_issue_stage with a behavioural ALU in the loop
module tb_alu_issue_stage;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_acc_sel = 1'b0, out_ready = 1'b1;
  logic [15:0] in_a = '0, in_b = '0, alu_a, alu_b, alu_result, out_result, acc;
  logic [2:0] in_op = '0, alu_ctrl;
  logic in_ready, out_valid, out_zero, out_carry, out_ovf, out_illegal;
  int vec = 0, errs = 0;
  always #5 clk = ~clk;
  always_comb begin
    alu_result = 16'hDEAD;
    case (alu_ctrl)
      3'd0: alu_result = alu_a + alu_b;
      3'd1: alu_result = alu_a - alu_b;
      3'd2: alu_result = alu_a & alu_b;
      3'd3: alu_result = alu_a | alu_b;
      3'd4: alu_result = alu_a ^ alu_b;
      default: alu_result = 16'hDEAD;
    endcase
  end
  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc_sel(in_acc_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_carry(out_carry), .out_ovf(out_ovf),
    .out_illegal(out_illegal), .acc(acc)
  );
  task automatic step;
    @(posedge clk);
    #2;
  endtask
  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op, input logic sel);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_op = op;
    in_acc_sel = sel;
    #1;
  endtask
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op, input logic sel);
    int n = 0;
    drive(a, b, op, sel);
    while (!in_ready && n < 8) begin
      step;
      n++;
    end
    vec++;
    if (n >= 8) begin errs++; $display("FAIL send_timeout in_ready=%0b required 1", in_ready); end
    step;
    in_valid = 1'b0;
    in_acc_sel = 1'b0;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    step;
    step;
    vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    vec++; if (acc !== 16'h0) begin errs++; $display("FAIL rst_acc got %h exp 0000", acc); end
    vec++; if ({alu_a, alu_b, alu_ctrl} !== 35'h0) begin errs++; $display("FAIL rst_alu got %h %h %h exp 0", alu_a, alu_b, alu_ctrl); end
    vec++; if (out_result !== 16'h0) begin errs++; $display("FAIL rst_result got %h exp 0000", out_result); end
    rst_n = 1'b1;
    send(16'h0007, 16'h0001, 3'd0, 1'b0);
    rst_n = 1'b0;
    step;
    step;
    rst_n = 1'b1;
    #1;
    vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL mid_rst_out_valid got %b exp 0", out_valid); end
    vec++; if (acc !== 16'h0) begin errs++; $display("FAIL mid_rst_acc got %h exp 0000", acc); end
    vec++; if (in_ready !== 1'b1) begin errs++; $display("FAIL mid_rst_in_ready got %b exp 1", in_ready); end
    vec++; if (alu_a !== 16'h0) begin errs++; $display("FAIL mid_rst_alu_a got %h exp 0000", alu_a); end
    step;
    step;
    vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL mid_rst_no_partial got %b exp 0", out_valid); end
  endtask
  task automatic test_add_carry;
    send(16'hFFFF, 16'h0001, 3'd0, 1'b0);
    vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL add_latency got %b exp 0", out_valid); end
    step;
    vec++; if (out_valid !== 1'b1) begin errs++; $display("FAIL add_valid got %b exp 1", out_valid); end
    vec++; if (out_result !== 16'h0000) begin errs++; $display("FAIL add_result got %h exp 0000", out_result); end
    vec++; if ({out_zero, out_carry, out_ovf, out_illegal} !== 4'b1100) begin errs++; $display("FAIL add_flags zcoi got %b exp 1100", {out_zero, out_carry, out_ovf, out_illegal}); end
    step;
    vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL add_drain got %b exp 0", out_valid); end
  endtask
  task automatic test_sub;
    send(16'h8000, 16'h0001, 3'd1, 1'b0);
    step;
    vec++; if (out_result !== 16'h7FFF) begin errs++; $display("FAIL sub_ovf_result got %h exp 7fff", out_result); end
    vec++; if ({out_zero, out_carry, out_ovf, out_illegal} !== 4'b0010) begin errs++; $display("FAIL sub_ovf_flags zcoi got %b exp 0010", {out_zero, out_carry, out_ovf, out_illegal}); end
    send(16'h0003, 16'h0005, 3'd1, 1'b0);
    step;
    vec++; if (out_result !== 16'hFFFE) begin errs++; $display("FAIL sub_borrow_result got %h exp fffe", out_result); end
    vec++; if ({out_zero, out_carry, out_ovf, out_illegal} !== 4'b0100) begin errs++; $display("FAIL sub_borrow_flags zcoi got %b exp 0100", {out_zero, out_carry, out_ovf, out_illegal}); end
    send(16'h00F0, 16'h003C, 3'd4, 1'b0);
    step;
    vec++; if ({out_result, out_carry, out_ovf} !== {16'h00CC, 2'b00}) begin errs++; $display("FAIL xor_result got %h c%b o%b exp 00cc c0 o0", out_result, out_carry, out_ovf); end
    step;
  endtask
  task automatic test_acc_chain;
    drive(16'h0005, 16'h0003, 3'd0, 1'b0);
    vec++; if (in_ready !== 1'b1) begin errs++; $display("FAIL chain_first_ready got %b exp 1", in_ready); end
    step;
    drive(16'hAAAA, 16'h0002, 3'd1, 1'b1);
    vec++; if (in_ready !== 1'b0) begin errs++; $display("FAIL chain_hazard_ready got %b exp 0", in_ready); end
    step;
    vec++; if (in_ready !== 1'b1) begin errs++; $display("FAIL chain_resume_ready got %b exp 1", in_ready); end
    vec++; if (out_result !== 16'h0008 || acc !== 16'h0008) begin errs++; $display("FAIL chain_first got %h acc %h exp 0008 acc 0008", out_result, acc); end
    step;
    in_valid = 1'b0;
    in_acc_sel = 1'b0;
    step;
    vec++; if (out_result !== 16'h0006 || out_valid !== 1'b1) begin errs++; $display("FAIL chain_second got %h v%b exp 0006 v1", out_result, out_valid); end
    vec++; if (acc !== 16'h0006) begin errs++; $display("FAIL chain_acc got %h exp 0006", acc); end
    step;
  endtask
  task automatic test_backpressure;
    out_ready = 1'b0;
    drive(16'h0010, 16'h0001, 3'd0, 1'b0);
    vec++; if (in_ready !== 1'b1) begin errs++; $display("FAIL bp_accept1 got %b exp 1", in_ready); end
    step;
    drive(16'h0020, 16'h0002, 3'd0, 1'b0);
    vec++; if (in_ready !== 1'b1) begin errs++; $display("FAIL bp_accept2 got %b exp 1", in_ready); end
    step;
    drive(16'h0030, 16'h0003, 3'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      vec++; if (in_ready !== 1'b0) begin errs++; $display("FAIL bp_stall_ready[%0d] got %b exp 0", i, in_ready); end
      vec++; if (out_valid !== 1'b1 || out_result !== 16'h0011) begin errs++; $display("FAIL bp_hold[%0d] got %h v%b exp 0011 v1", i, out_result, out_valid); end
      step;
    end
    out_ready = 1'b1;
    #1;
    vec++; if (in_ready !== 1'b1) begin errs++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
    step;
    in_valid = 1'b0;
    vec++; if (out_valid !== 1'b1 || out_result !== 16'h0022) begin errs++; $display("FAIL bp_second got %h v%b exp 0022 v1", out_result, out_valid); end
    step;
    vec++; if (out_valid !== 1'b1 || out_result !== 16'h0033) begin errs++; $display("FAIL bp_third got %h v%b exp 0033 v1", out_result, out_valid); end
    step;
    vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL bp_empty got %b exp 0", out_valid); end
  endtask
  task automatic test_illegal;
    send(16'h1234, 16'h1111, 3'd6, 1'b0);
    step;
    vec++; if (out_result !== 16'h0000) begin errs++; $display("FAIL illegal_result got %h exp 0000", out_result); end
    vec++; if ({out_zero, out_carry, out_ovf, out_illegal} !== 4'b1001) begin errs++; $display("FAIL illegal_flags zcoi got %b exp 1001", {out_zero, out_carry, out_ovf, out_illegal}); end
    vec++; if (acc !== 16'h0033) begin errs++; $display("FAIL illegal_acc got %h exp 0033", acc); end
    send(16'hFFFF, 16'h0000, 3'd0, 1'b1);
    step;
    vec++; if (out_result !== 16'h0033 || out_illegal !== 1'b0) begin errs++; $display("FAIL illegal_acc_reuse got %h i%b exp 0033 i0", out_result, out_illegal); end
    step;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset;
    test_add_carry;
    test_sub;
    test_acc_chain;
    test_backpressure;
    test_illegal;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
